// File: rtl/level_dispatch_if.sv
// Queue-consumer / level-control handshake bundle for level_dispatch.
// master = dispatcher side, slave = queue plus downstream level control.
interface level_dispatch_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              stop;
  logic              Qempty;
  logic [DATA_W-1:0] dataFromQ;
  logic              deQ;
  logic              lcDone;
  logic              startLC;
  logic [DATA_W-1:0] dataToLC;
  logic [2:0]        levels;
  logic              busy;
  logic              drained;
  logic [CNT_W-1:0]  dispatchCount;

  modport master (
    input  stop, Qempty, dataFromQ, lcDone,
    output deQ, startLC, dataToLC, levels,
    output busy, drained, dispatchCount
  );

  modport slave (
    output stop, Qempty, dataFromQ, lcDone,
    input  deQ, startLC, dataToLC, levels,
    input  busy, drained, dispatchCount
  );
endinterface

// File: rtl/level_dispatch.sv
// Pops queue entries one at a time and hands each to the
// next-level control block, waiting for lcDone between entries.
module level_dispatch #(
  parameter int          DATA_W = 64,
  parameter int unsigned LEVEL  = 1,
  parameter int          CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  level_dispatch_if.master bus
);

  localparam logic [2:0] LVL = 3'(LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              deq_q, deq_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        lvl_q, lvl_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    deq_d   = 1'b0;
    start_d = 1'b0;
    lvl_d   = 3'b000;
    data_d  = data_q;
    busy_d  = 1'b1;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!bus.Qempty && !bus.stop) begin
          state_d = LOAD;
          deq_d   = 1'b1;
          data_d  = bus.dataFromQ;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d = START;
        start_d = 1'b1;
        lvl_d   = LVL;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.lcDone) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      deq_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      lvl_q   <= 3'b000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      deq_q   <= deq_d;
      start_q <= start_d;
      data_q  <= data_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.deQ           = deq_q;
  assign bus.startLC       = start_q;
  assign bus.dataToLC      = data_q;
  assign bus.levels        = lvl_q;
  assign bus.busy          = busy_q;
  assign bus.dispatchCount = cnt_q;
  assign bus.drained       = bus.stop & bus.Qempty
                           & (state_q == IDLE);

endmodule

// File: tb/tb_level_dispatch.sv
// Directed bench for level_dispatch with an in-bench
// timeline model of each entry's life since its pop.
module tb_level_dispatch;

  logic clk = 1'b0;
  logic rst;

  level_dispatch_if #(.DATA_W(64), .CNT_W(16)) bus1 ();
  level_dispatch_if #(.DATA_W(64), .CNT_W(2))  bus2 ();

  level_dispatch #(.DATA_W(64), .LEVEL(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  level_dispatch #(.DATA_W(64), .LEVEL(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.stop      = bus1.stop;
  assign bus2.Qempty    = bus1.Qempty;
  assign bus2.dataFromQ = bus1.dataFromQ;
  assign bus2.lcDone    = bus1.lcDone;

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int deq_n = 0;
  int last_deq = 0;
  int prev_deq = 0;
  int start_cyc = 0;
  logic [63:0] q[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Model: an entry in flight is described by its age in cycles
  // since the edge that captured it.
  bit          m_act;
  int          m_age;
  logic [63:0] m_data;
  int          m_cnt;
  int          m_cnt2;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 0; m_age = 0; m_data = '0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (!m_act) begin
      if (!bus1.Qempty && !bus1.stop) begin
        m_act = 1; m_age = 0; m_data = bus1.dataFromQ;
      end
    end else if (m_age >= 2 && bus1.lcDone) begin
      m_act = 0;
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
      end
    end
    #1;
    begin
      bit e_deq, e_st;
      e_deq = m_act && m_age == 0;
      e_st  = m_act && m_age == 1;
      chk("deQ", 64'(bus1.deQ), 64'(e_deq));
      chk("startLC", 64'(bus1.startLC), 64'(e_st));
      chk("levels", 64'(bus1.levels), e_st ? 64'd1 : 64'd0);
      chk("dataToLC", bus1.dataToLC, m_data);
      chk("busy", 64'(bus1.busy), 64'(m_act));
      chk("drained", 64'(bus1.drained),
          64'(bus1.stop && bus1.Qempty && !m_act));
      chk("count", 64'(bus1.dispatchCount), 64'(m_cnt));
      chk("count2", 64'(bus2.dispatchCount), 64'(m_cnt2));
      if (bus1.deQ) begin
        deq_n++;
        prev_deq = last_deq;
        last_deq = cyc;
      end
      if (bus1.startLC) start_cyc = cyc;
    end
  end

  // Queue behaviour: first-word-fall-through head, popped on deQ
  initial begin
    bus1.Qempty = 1'b1;
    bus1.dataFromQ = '0;
    forever begin
      @(negedge clk);
      if (bus1.deQ && q.size() > 0) void'(q.pop_front());
      #1;
      bus1.Qempty = (q.size() == 0);
      bus1.dataFromQ = (q.size() > 0) ? q[0] : 64'd0;
    end
  end

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus1.startLC) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      err++;
      $display("FAIL wait_start: no startLC within 30 cycles");
    end
  endtask

  task automatic dispatch(input int delay);
    bit ok;
    wait_start(ok);
    if (ok) begin
      repeat (delay) @(negedge clk);
      bus1.lcDone = 1'b1;
      @(negedge clk);
      bus1.lcDone = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int n0;
    rst = 1'b1;
    bus1.stop = 1'b0;
    bus1.lcDone = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_deQ", 64'(bus1.deQ), 64'd0);
    chk("rst_busy", 64'(bus1.busy), 64'd0);
    chk("rst_drained", 64'(bus1.drained), 64'd0);
    chk("rst_data", bus1.dataToLC, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_deq", 64'(deq_n), 64'd0);

    // single entry
    q.push_back(64'hFFF0F0F0F0F0F0FF);
    wait_start(ok);
    chk("t2_data", bus1.dataToLC, 64'hFFF0F0F0F0F0F0FF);
    chk("t2_levels", 64'(bus1.levels), 64'd1);
    chk("t2_lat", 64'(start_cyc - last_deq), 64'd1);
    repeat (3) @(negedge clk);
    bus1.lcDone = 1'b1;
    @(negedge clk);
    bus1.lcDone = 1'b0;
    @(negedge clk);
    chk("t2_idle", 64'(bus1.busy), 64'd0);
    chk("t2_count", 64'(bus1.dispatchCount), 64'd1);

    // back-to-back A, B
    q.push_back(64'hA5A5_0000_1111_2222);
    q.push_back(64'h0123_4567_89AB_CDEF);
    dispatch(1);
    dispatch(1);
    chk("t3_data", bus1.dataToLC, 64'h0123_4567_89AB_CDEF);
    chk("t3_spacing", 64'(last_deq - prev_deq), 64'd4);
    chk("t3_count", 64'(bus1.dispatchCount), 64'd3);

    // lcDone coincident with startLC is ignored
    q.push_back(64'hDEAD_BEEF_0000_0004);
    dispatch(0);
    repeat (3) @(negedge clk);
    chk("coinc_busy", 64'(bus1.busy), 64'd1);
    bus1.lcDone = 1'b1;
    @(negedge clk);
    bus1.lcDone = 1'b0;
    @(negedge clk);
    chk("coinc_done", 64'(bus1.busy), 64'd0);

    // stop during WAIT with three queued
    q.push_back(64'h1); q.push_back(64'h2); q.push_back(64'h3);
    wait_start(ok);
    @(negedge clk);
    bus1.stop = 1'b1;
    bus1.lcDone = 1'b1;
    @(negedge clk);
    bus1.lcDone = 1'b0;
    n0 = deq_n;
    repeat (8) @(negedge clk);
    chk("stop_no_deq", 64'(deq_n), 64'(n0));
    chk("stop_busy", 64'(bus1.busy), 64'd0);
    chk("stop_drained", 64'(bus1.drained), 64'd0);
    bus1.stop = 1'b0;
    @(negedge clk);
    chk("resume_deq", 64'(bus1.deQ), 64'd1);
    dispatch(1);
    dispatch(1);
    bus1.stop = 1'b1;
    repeat (3) @(negedge clk);
    chk("drained", 64'(bus1.drained), 64'd1);
    chk("t4_count", 64'(bus1.dispatchCount), 64'd7);
    chk("sat_count2", 64'(bus2.dispatchCount), 64'd3);
    bus1.stop = 1'b0;

    // reset mid-WAIT
    q.push_back(64'h5555_AAAA_5555_AAAA);
    wait_start(ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus1.busy), 64'd0);
    chk("arst_data", bus1.dataToLC, 64'd0);
    chk("arst_count", 64'(bus1.dispatchCount), 64'd0);
    bus1.lcDone = 1'b1;
    @(negedge clk);
    bus1.lcDone = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus1.lcDone = 1'b1;
    @(negedge clk);
    bus1.lcDone = 1'b0;
    chk("post_rst_busy", 64'(bus1.busy), 64'd0);
    q.push_back(64'hC0C0_C0C0_C0C0_C0C0);
    dispatch(2);
    repeat (2) @(negedge clk);
    chk("post_rst_data", bus1.dataToLC, 64'hC0C0_C0C0_C0C0_C0C0);
    chk("post_rst_count", 64'(bus1.dispatchCount), 64'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
